sobel_controller: RTL
=====================

Name: sobel_controller

Overview:
- Sequencing controller for the Sobel datapath (input selector + loader + gradient unit).
- Takes a pixel stream with a valid/ready handshake and drives the datapath Enable one load step at a time.
- Skips source consumption on padding steps and captures each completed window's Gradient/Dop with its coordinates into a 2-entry output FIFO.
- Presents results on a valid/ready stream, frames runs with Start/Done, and latches the threshold T per frame.

Parameters:
DATA_W, 8, pixel/gradient width
COORD_W, 8, row/column coordinate width
FRAME_CNT_W, 16, width of completed-frame counter

Ports:
Clk  in  1  clock, all logic rising-edge
Reset  in  1  asynchronous active-low reset
Start  in  1  one-cycle frame start request; honoured only in IDLE
Abort  in  1  synchronous abort, any state
T_In  in  DATA_W  threshold, sampled on accepted Start
Src_Data  in  DATA_W  pixel from source
Src_Valid  in  1  source pixel available
Src_Ready  out  1  pixel consumed this cycle
Dp_Enable  out  1  datapath Enable (one load step)
Dp_DataIn  out  DATA_W  datapath DataIn (= Src_Data, combinational)
Dp_T  out  DATA_W  latched threshold to datapath T
Dp_isPadding  in  1  datapath padding indication for current step
Dp_isReady  in  1  datapath window complete
Dp_isEnd  in  1  datapath last window
Dp_Gradient  in  DATA_W  datapath gradient magnitude
Dp_Dop  in  1  datapath edge decision
Dp_Row  in  COORD_W  datapath Out_Row
Dp_Column  in  COORD_W  datapath Out_Column
Res_Gradient  out  DATA_W  FIFO head gradient
Res_Edge  out  1  FIFO head Dop
Res_Row  out  COORD_W  FIFO head row
Res_Column  out  COORD_W  FIFO head column
Res_Valid  out  1  FIFO non-empty
Res_Ready  in  1  sink accepts head
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse at frame completion
Frame_Count  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- Reset (Reset=0, async):
  - State=IDLE; Dp_T=0; FIFO empty; Frame_Count=0.
  - Res_Valid, Done, Busy, Dp_Enable, Src_Ready all 0; stepped_d=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Start=1 -> latch T_In into Dp_T, go RUN.
  - Start is ignored in any other state.
- RUN, step condition and Dp_Enable:
  - credit = FIFO count + stepped_d.
  - Dp_Enable = (Dp_isPadding | Src_Valid) & (credit < 2).
  - Src_Ready = Dp_Enable & ~Dp_isPadding; a padding step consumes no source pixel.
  - Dp_Enable and Src_Ready are 0 outside RUN.
- stepped_d: register of Dp_Enable.
- Capture:
  - Condition: stepped_d=1 and Dp_isReady=1, i.e. the cycle after the step that loaded the window. Latency from the completing step to capture is 1 cycle.
  - Action: push {Dp_Gradient, Dp_Dop, Dp_Row, Dp_Column} into the FIFO.
  - The credit rule guarantees the FIFO is never full at capture; overflow is a design error and carries an assertion.
- Frame end:
  - Capture with Dp_isEnd=1 -> go DRAIN.
  - stepped_d=1 with Dp_isEnd=1 but Dp_isReady=0 -> also go DRAIN, no push.
  - No further Dp_Enable after the transition.
- DRAIN: FIFO empty -> DONE.
- DONE (one cycle):
  - Done=1; Frame_Count+1 (wraps at 2^FRAME_CNT_W); then IDLE.
- FIFO (2 entries):
  - Res_* reflect the head and stay stable while Res_Valid=1 and Res_Ready=0.
  - Pop on Res_Valid & Res_Ready.
  - Simultaneous push and pop is legal; count unchanged, order preserved.
- Abort=1 (any state):
  - Next cycle: IDLE, FIFO flushed, stepped_d=0; Dp_T held.
  - No Done pulse, Frame_Count unchanged.
  - Abort has priority over Start and capture in the same cycle.
- Backpressure: with Res_Ready=0 at most 2 results are outstanding; Dp_Enable is 0 until a pop frees credit.
- Datapath contract:
  - The datapath loader state is cleared only by system reset.
  - An aborted frame leaves it mid-image; recovery requires system reset. This is documented, not handled.

Decomposition:
- Package sobel_ctrl_pkg: state enum (IDLE, RUN, DRAIN, DONE), DATA_W/COORD_W defaults, result record layout (gradient, edge, row, column).
- One sub-module: sobel_result_fifo, a 2-entry synchronous FIFO with flush, count and simultaneous push/pop.

Test Plan:
- Reset mid-RUN with 1 entry in FIFO -> all outputs 0 immediately, state IDLE, Frame_Count=0.
- Start with T_In=8'd50, source always valid, Res_Ready=1, 4x4 datapath image -> Dp_T=50, captures match datapath windows in order, one Done pulse, Frame_Count=1.
- Padding step (Dp_isPadding=1) with Src_Valid=0 -> Dp_Enable=1, Src_Ready=0, no pixel consumed.
- Res_Ready=0 for 20 cycles after first capture -> Res_Valid=1 with stable Res_* values, FIFO count reaches 2, Dp_Enable stays 0 until the first pop.
- Abort asserted together with a capture cycle and Start -> next cycle IDLE, Res_Valid=0, no Done pulse, Frame_Count unchanged.
- Start pulsed during RUN -> ignored, Dp_T unchanged; pop and capture in the same cycle -> FIFO count unchanged, order correct.

Source files
------------

// File: rtl/sobel_controller_pkg.sv
// Shared types for the Sobel sequencing controller:
// FSM states, default widths and the captured result layout.
package sobel_ctrl_pkg;

    localparam int DATA_W_D      = 8;
    localparam int COORD_W_D     = 8;
    localparam int FRAME_CNT_W_D = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W_D-1:0]  gradient;
        logic                 dop;
        logic [COORD_W_D-1:0] row;
        logic [COORD_W_D-1:0] column;
    } res_t;

    function automatic int res_w(input int dw, input int cw);
        return dw + 1 + 2 * cw;
    endfunction

endpackage

// File: rtl/sobel_controller_if.sv
// Result stream of the Sobel controller: FIFO head plus
// a valid/ready handshake towards the sink.
interface sobel_res_if
    import sobel_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int COORD_W = COORD_W_D
);
    logic [DATA_W-1:0]  Res_Gradient;
    logic               Res_Edge;
    logic [COORD_W-1:0] Res_Row;
    logic [COORD_W-1:0] Res_Column;
    logic               Res_Valid;
    logic               Res_Ready;

    modport master (
        output Res_Gradient,
        output Res_Edge,
        output Res_Row,
        output Res_Column,
        output Res_Valid,
        input  Res_Ready
    );

    modport slave (
        input  Res_Gradient,
        input  Res_Edge,
        input  Res_Row,
        input  Res_Column,
        input  Res_Valid,
        output Res_Ready
    );
endinterface

// File: rtl/sobel_controller_result_fifo.sv
// Two-entry result FIFO with flush; a push and a pop in the
// same cycle keep the count and the ordering.
module sobel_result_fifo #(
    parameter int W = 25
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wr <= ~r_wr;
            if (i_pop)  r_rd <= ~r_rd;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // The step credit must keep a capture from ever landing on a full FIFO
    a_no_overflow : assert property (
        @(posedge Clk) disable iff (!Reset)
        !(i_push && !i_flush && !i_pop && r_count == 2'd2)
    );
endmodule

// File: rtl/sobel_controller.sv
// Sobel sequencing controller: steps the datapath one load at a
// time under result-FIFO credit and frames runs with Start/Done.
module sobel_controller
    import sobel_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_D,
    parameter int COORD_W     = COORD_W_D,
    parameter int FRAME_CNT_W = FRAME_CNT_W_D
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [DATA_W-1:0]      T_In,
    input  logic [DATA_W-1:0]      Src_Data,
    input  logic                   Src_Valid,
    output logic                   Src_Ready,
    output logic                   Dp_Enable,
    output logic [DATA_W-1:0]      Dp_DataIn,
    output logic [DATA_W-1:0]      Dp_T,
    input  logic                   Dp_isPadding,
    input  logic                   Dp_isReady,
    input  logic                   Dp_isEnd,
    input  logic [DATA_W-1:0]      Dp_Gradient,
    input  logic                   Dp_Dop,
    input  logic [COORD_W-1:0]     Dp_Row,
    input  logic [COORD_W-1:0]     Dp_Column,
    sobel_res_if.master            res,
    output logic                   Busy,
    output logic                   Done,
    output logic [FRAME_CNT_W-1:0] Frame_Count
);
    localparam int RW = res_w(DATA_W, COORD_W);
    localparam logic [FRAME_CNT_W-1:0] ONE = 1;

    state_t                 r_state;
    logic                   r_stepped;
    logic                   r_busy;
    logic                   r_done;
    logic [DATA_W-1:0]      r_t;
    logic [FRAME_CNT_W-1:0] r_frames;

    logic [1:0]    w_count;
    logic [1:0]    w_credit;
    logic          w_end;
    logic          w_step;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [RW-1:0] w_head;

    // Outstanding results include the step whose window may land next cycle
    assign w_credit = w_count + {1'b0, r_stepped};
    assign w_end    = r_stepped & Dp_isEnd;
    assign w_step   = (r_state == RUN) & ~w_end
                    & (Dp_isPadding | Src_Valid)
                    & (w_credit < 2'd2);
    assign w_push   = r_stepped & Dp_isReady;
    assign w_valid  = (w_count != 2'd0);
    assign w_pop    = w_valid & res.Res_Ready;

    assign Dp_Enable = w_step;
    assign Src_Ready = w_step & ~Dp_isPadding;
    assign Dp_DataIn = Src_Data;
    assign Dp_T      = r_t;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Frame_Count = r_frames;

    sobel_result_fifo #(.W(RW)) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_flush (Abort),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({Dp_Gradient, Dp_Dop, Dp_Row, Dp_Column}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign {res.Res_Gradient, res.Res_Edge,
            res.Res_Row, res.Res_Column} = w_head;
    assign res.Res_Valid = w_valid;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_stepped <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_t       <= '0;
            r_frames  <= '0;
        end else if (Abort) begin
            r_state   <= IDLE;
            r_stepped <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_stepped <= w_step;
            r_done    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_t     <= T_In;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_end) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!w_valid) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_frames <= r_frames + ONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
